// File: rtl/pcihellocore_pio_pkg.sv
// Shared constants for the pcihellocore edge-capturing input PIO.
// Register word addresses, edge-mode selectors and a counter-width helper.
package pcihellocore_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA     = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE     = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // A counter that must reach cycles-1 needs clog2(cycles) bits; keep at least one.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/pcihellocore_pio_debounce.sv
// One input bit: two-flop synchroniser followed by an optional stability
// counter. With PCIHELLOCORE_PIO_DEBOUNCE_EN undefined the counter is absent
// and the debounced value follows the synchroniser every clock.
// 'change' is high on the clock where 'deb' will take 'new_val'.
module pcihellocore_pio_debounce
  import pcihellocore_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic deb,
  output logic change,
  output logic new_val
);

  logic sync1;
  logic sync2;

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  assign new_val = sync2;

`ifdef PCIHELLOCORE_PIO_DEBOUNCE_EN
  localparam int               CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign change = (sync2 != deb) && (cnt == CNT_LAST);

  // Count consecutive clocks the input disagrees with deb; any agreement restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if ((sync2 != deb) && !change) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end
`else
  assign change = (sync2 != deb);
`endif

  // Debounced value register; updates only when the input has been stable long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= RESET_VALUE;
    end else if (change) begin
      deb <= sync2;
    end
  end

endmodule

// File: rtl/pcihellocore_pio_in_edge.sv
// Avalon-MM input PIO with per-bit synchroniser, optional debounce
// (PCIHELLOCORE_PIO_DEBOUNCE_EN), edge capture and a masked level interrupt.
//
// Bus protocol: Avalon-MM slave without wait states. A write is accepted on
// any clock where chipselect && !write_n; readdata always reflects the
// register selected by address on the previous clock (fixed latency 1,
// no read strobe needed).
module pcihellocore_pio_in_edge
  import pcihellocore_pio_pkg::*;
#(
  parameter int               WIDTH           = 32,
  parameter int               EDGE_MODE       = 0,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] change;
  logic [WIDTH-1:0] new_val;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rd_next;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pcihellocore_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (RESET_VALUE[i])
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .din     (in_port[i]),
      .deb     (deb[i]),
      .change  (change[i]),
      .new_val (new_val[i])
    );
  end

  assign wr_en = chipselect && !write_n;

  // Select which debounced transitions count as edges.
  always_comb begin
    edge_evt = '0;
    case (EDGE_MODE)
      EDGE_RISING:  edge_evt = change & new_val;
      EDGE_FALLING: edge_evt = change & ~new_val;
      default:      edge_evt = change;
    endcase
  end

  // Write-1-to-clear mask for the edge register.
  always_comb begin
    edge_clr = '0;
    if (wr_en && (address == PIO_ADDR_EDGE)) begin
      edge_clr = writedata[WIDTH-1:0];
    end
  end

  // Edge capture: a new event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~edge_clr) | edge_evt;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (wr_en && (address == PIO_ADDR_IRQ_MASK)) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // Read mux; upper bits beyond WIDTH stay zero.
  always_comb begin
    rd_next = '0;
    case (address)
      PIO_ADDR_DATA:     rd_next[WIDTH-1:0] = deb;
      PIO_ADDR_IRQ_MASK: rd_next[WIDTH-1:0] = irq_mask;
      PIO_ADDR_EDGE:     rd_next[WIDTH-1:0] = edge_capture;
      default:           rd_next = '0;
    endcase
  end

  // Registered read data, refreshed every clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pcihellocore_pio_in_edge.sv
// Bench for pcihellocore_pio_in_edge: three instances (rising, falling, any
// edge) share one bus and input, and every clock their readdata/irq are
// compared with a behavioural model of the register map.
module tb_pcihellocore_pio_in_edge;

  localparam int W  = 4;
  localparam int DC = 4;
`ifdef PCIHELLOCORE_PIO_DEBOUNCE_EN
  localparam int EFF_DB = DC;
`else
  localparam int EFF_DB = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd0, rd1, rd2;
  logic          irq0, irq1, irq2;

  pcihellocore_pio_in_edge #(.WIDTH(W), .EDGE_MODE(0), .DEBOUNCE_CYCLES(DC), .RESET_VALUE('0)) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));
  pcihellocore_pio_in_edge #(.WIDTH(W), .EDGE_MODE(1), .DEBOUNCE_CYCLES(DC), .RESET_VALUE('0)) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd1), .irq(irq1));
  pcihellocore_pio_in_edge #(.WIDTH(W), .EDGE_MODE(2), .DEBOUNCE_CYCLES(DC), .RESET_VALUE('0)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));

  // ---------------- reference model ----------------
  // The synchronised input is modelled as a 2-clock delay line; a bit's
  // debounced value flips once the delayed input has disagreed with it on
  // each of the last EFF_DB clocks, all of them after its previous flip.
  logic [W-1:0]  m_s1, m_s2, m_deb, m_mask;
  logic [W-1:0]  m_hist[$];
  int            m_since[W];
  logic [W-1:0]  m_edge[3];
  logic [31:0]   m_rd[3];

  int checks = 0;
  int errors = 0;

  function automatic void model_edge();
    logic [W-1:0] chg, newv, clr;
    bit all_diff;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_mask = '0;
      m_hist.delete();
      for (int b = 0; b < W; b++) m_since[b] = 0;
      for (int d = 0; d < 3; d++) begin m_edge[d] = '0; m_rd[d] = '0; end
      return;
    end
    for (int d = 0; d < 3; d++) begin
      case (address)
        2'd0:    m_rd[d] = {28'd0, m_deb};
        2'd2:    m_rd[d] = {28'd0, m_mask};
        2'd3:    m_rd[d] = {28'd0, m_edge[d]};
        default: m_rd[d] = '0;
      endcase
    end
    m_hist.push_front(m_s2);
    if (m_hist.size() > EFF_DB) void'(m_hist.pop_back());
    chg = '0;
    for (int b = 0; b < W; b++) begin
      m_since[b]++;
      if (m_since[b] >= EFF_DB && m_hist.size() >= EFF_DB) begin
        all_diff = 1'b1;
        for (int i = 0; i < EFF_DB; i++) if (m_hist[i][b] == m_deb[b]) all_diff = 1'b0;
        if (all_diff) begin chg[b] = 1'b1; m_since[b] = 0; end
      end
    end
    newv = m_deb ^ chg;
    m_deb = newv;
    clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
    m_edge[0] = (m_edge[0] & ~clr) | (chg & newv);
    m_edge[1] = (m_edge[1] & ~clr) | (chg & ~newv);
    m_edge[2] = (m_edge[2] & ~clr) | chg;
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    m_s2 = m_s1;
    m_s1 = in_port;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("rd_rise", rd0, m_rd[0]);
    check("rd_fall", rd1, m_rd[1]);
    check("rd_any",  rd2, m_rd[2]);
    check("irq_rise", {31'd0, irq0}, {31'd0, |(m_edge[0] & m_mask)});
    check("irq_fall", {31'd0, irq1}, {31'd0, |(m_edge[1] & m_mask)});
    check("irq_any",  {31'd0, irq2}, {31'd0, |(m_edge[2] & m_mask)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_reset(input logic [W-1:0] pins);
    reset = 1'b1; in_port = pins;
    step(); step();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;

    // Reset with all pins high; registers read zero, then DATA fills in.
    do_reset(4'hF);
    check("irq_in_reset", {31'd0, irq0 | irq1 | irq2}, 32'd0);
    address = 2'd0; step();
    address = 2'd2; step();
    address = 2'd3; step();
    address = 2'd0; repeat (8) step();
    check("data_after_reset", rd0, 32'hF);

    // Glitch then held change on bit 0.
    do_reset(4'h0);
    repeat (4) step();
    in_port = 4'h1; step(); step();
    in_port = 4'h0; step();
    in_port = 4'h1; repeat (8) step();
    address = 2'd3; step(); step();

    // Masked interrupt, clear, unmasked edge on bit 1.
    bus_write(2'd2, 32'h1);
    bus_write(2'd3, 32'hF);
    in_port = 4'h0; repeat (8) step();
    bus_write(2'd3, 32'hF);
    in_port = 4'h1; repeat (8) step();
    bus_write(2'd3, 32'h1);
    step();
    in_port = 4'h3; repeat (8) step();

    // Clear written on exactly the clock bit 0 rises: the set must win.
    bus_write(2'd3, 32'hF);
    in_port = 4'h0; repeat (8) step();
    bus_write(2'd3, 32'hF);
    in_port = 4'h1;
    repeat (EFF_DB + 1) step();
    bus_write(2'd3, 32'h1);
    address = 2'd3; step(); step();
    check("collision_edge0", {31'd0, rd0[0]}, 32'd1);
    check("collision_irq",   {31'd0, irq0}, 32'd1);

    // Bit 2 falling (falling instance) and an any-edge pulse re-captured after clear.
    bus_write(2'd3, 32'hF);
    in_port = 4'h4; repeat (8) step();
    bus_write(2'd3, 32'hF);
    in_port = 4'h0; repeat (8) step();
    address = 2'd3; step(); step();
    check("falling_bit2", rd1, 32'h4);

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 4) == 0) in_port = 4'($urandom_range(0, 15));
      address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
      end else begin
        chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1; writedata = $urandom;
      end
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    chipselect = 1'b0; write_n = 1'b1; reset = 1'b0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcihellocore_pio_in_edge.md
# pcihellocore_pio_in_edge

Parametrised Avalon-MM input PIO for the pcihellocore Qsys system. It is the successor to the fixed 32-bit, data-only button port. It adds:
- a two-flop input synchroniser,
- optional per-bit debounce,
- a per-bit edge-capture register with selectable edge polarity,
- an interrupt mask and a level `irq` output to the PCIe bridge.

Read data stays registered, with a fixed one-cycle latency.

## Interface
Parameters:
- `WIDTH`, 32, number of input bits (1..32)
- `EDGE_MODE`, 0, captured edge type: 0 rising, 1 falling, 2 any
- `DEBOUNCE_CYCLES`, 16, consecutive stable cycles required before the debounced value changes (≥1; used only with debounce compiled in)
- `RESET_VALUE`, 0, reset value of the debounced data register (WIDTH bits)

Ports:
- `clk` in 1: sole clock. One clock; every flop is on `clk`.
- `reset` in 1: reset is synchronous and active-high.
- `address` in 2: register select
- `chipselect` in 1: slave select
- `write_n` in 1: active-low write strobe, qualified by `chipselect`
- `writedata` in 32: write data
- `in_port` in WIDTH: asynchronous external inputs
- `readdata` out 32: registered read data
- `irq` out 1: level interrupt

## Operation
Register map (word addresses):
- 0 DATA: debounced input, read-only; writes are ignored.
- 1: reads 0, writes ignored.
- 2 IRQ_MASK: read/write, WIDTH bits.
- 3 EDGE_CAPTURE: read; write-1-to-clear per bit.

General rules:
- Unused upper bits (WIDTH..31) read as 0 on every register.
- Writes take effect when `chipselect && !write_n`.

Input path:
- Synchroniser: `sync1 <= in_port`, then `sync2 <= sync1`.
- Debounce, per bit, with counter `cnt` of width $clog2(DEBOUNCE_CYCLES):
  - If `sync2 != deb`: when `cnt == DEBOUNCE_CYCLES-1`, then `deb <= sync2` and `cnt <= 0`; otherwise `cnt++`.
  - If `sync2 == deb`: `cnt <= 0`. A glitch therefore restarts the count.

Edge capture, per bit:
- An edge event is the clock on which `deb` changes value. Rising means the new value is 1, falling means the new value is 0, any means either.
- On an event, the bit sets on the same edge as the `deb` update.
- A set and a write-1-clear on the same cycle leave the bit set; set wins.

Outputs:
- `irq = |(edge_capture & irq_mask)`, combinational from registers, with no extra flop.
- `readdata <=` mux(`address`) every cycle, independent of any read strobe. This gives read latency 1.

Reset values:
- `sync1`, `sync2`, `cnt`: 0.
- `deb`: `RESET_VALUE`.
- `edge_capture`, `irq_mask`, `readdata`: 0.
- `irq` is therefore 0 in reset.
- After reset the synchroniser refills from `in_port`. A difference from `RESET_VALUE` is then debounced as a normal input change.

Reset behaviour:
- Reset asserted mid-debounce discards the count.
- Reset asserted mid-operation clears any pending edges and deasserts `irq` on the next clock edge.

## Timing
- `in_port` sampled at edge k: `sync2` holds the value after edge k+1. The `deb` and edge-capture update happens at edge k+1+DEBOUNCE_CYCLES, and `irq` rises in the same cycle.
- Debounce compiled out: `deb` updates at edge k+2.
- Register write at edge w: the new value is visible in `readdata` after edge w+1 when `address` is held.
- `irq` falls in the cycle after the clearing write edge, or after the write edge that masks the bit.

## Configuration
- `PCIHELLOCORE_PIO_DEBOUNCE_EN` defined: per-bit debounce counters present, behaviour as above.
- Macro undefined: counters are removed and `deb <= sync2` every cycle. This is identical to `DEBOUNCE_CYCLES = 1`, and `DEBOUNCE_CYCLES` is ignored.

## Structure
- Package `pcihellocore_pio_pkg`:
  - address constants `PIO_ADDR_DATA=0`, `PIO_ADDR_IRQ_MASK=2`, `PIO_ADDR_EDGE=3`
  - edge-mode constants `EDGE_RISING=0`, `EDGE_FALLING=1`, `EDGE_ANY=2`
- Sub-module `pcihellocore_pio_debounce`: one bit (synchroniser, counter, `deb`), instantiated WIDTH times in a generate loop. The edge and register logic stays in the top module.

## Test plan
Bench parameters: WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_MODE=0, macro defined, unless noted otherwise.
- Reset check: assert `reset` for 2 cycles with `in_port=4'hF`, read addresses 0/2/3 immediately after → `readdata` 0 on each, `irq`=0; DATA reads 4'hF after 6 cycles.
- Debounce: set `in_port[0]` 0→1 for 2 cycles, back to 0, then 1 held → DATA[0] stays 0 during the glitch; becomes 1 exactly 5 edges after the held change is sampled (4 counts + synchroniser); EDGE[0]=1.
- Interrupt: write IRQ_MASK=4'b0001, produce a rising edge on bit 0 → `irq`=1; write EDGE=4'b0001 → `irq`=0 the next cycle; an edge on bit 1 (unmasked) sets EDGE[1] with `irq` staying 0.
- Clear collision: write EDGE=4'b0001 on the same cycle bit 0 debounces to 1 → EDGE[0] reads 1 afterwards.
- Edge modes: EDGE_MODE=1 with a 1→0 transition on bit 2 → EDGE=4'b0100; with EDGE_MODE=2 a 0→1→0 pulse sets the bit once, and after a clear, the second edge sets it again.
- Macro undefined: toggle `in_port[3]` for 1 cycle → DATA[3] follows 2 edges later for 1 cycle, and EDGE[3] sets.
